// File: rtl/game_timer_ctrl_pkg.sv
// Shared types and constants for the game round timer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        PAUSE    = 3'd2,
        WIN      = 3'd3,
        LOSE     = 3'd4,
        TIMEOVER = 3'd5
    } state_t;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [DIGIT_W-1:0] DIG_DASH  = 4'd10;
    localparam logic [DIGIT_W-1:0] DIG_BLANK = 4'd11;

endpackage

// File: rtl/game_timer_ctrl_bcd2_down_counter.sv
// Two-digit BCD down counter with load, saturating decrement and zero flag.
module bcd2_down_counter
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               dec,
    input  logic [DIGIT_W-1:0] load_tens,
    input  logic [DIGIT_W-1:0] load_ones,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               zero
);

    assign zero = (tens == '0) && (ones == '0);

    // Reset loads the same value as an explicit load, so the count resets to the round length.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            tens <= load_tens;
            ones <= load_ones;
        end else if (dec && !zero) begin
            if (ones == '0) begin
                ones <= 4'd9;
                tens <= tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round countdown sequencer: FSM, millisecond prescaler and display digit mux.
module game_timer_ctrl
    import game_pkg::*;
#(
    parameter int START_SEC     = 99,
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1k,
    input  logic        start,
    input  logic        pause,
    input  logic        success,
    input  logic        dot_game_over,
    output logic [31:0] digits,
    output logic        timeover,
    output logic        running,
    output logic [2:0]  state
);

    generate
        if (START_SEC < 0 || START_SEC > 99) begin : g_bad_start_sec
            $error("game_timer_ctrl: START_SEC must be in 0..99");
        end
    endgenerate

    localparam int unsigned MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(TICKS_PER_SEC - 1);
    localparam logic [DIGIT_W-1:0] START_TENS = DIGIT_W'(START_SEC / 10);
    localparam logic [DIGIT_W-1:0] START_ONES = DIGIT_W'(START_SEC % 10);
    localparam bit ZERO_ROUND = (START_SEC == 0);

    state_t            cur_state;
    logic [MS_W-1:0]   ms_cnt;
    logic [DIGIT_W-1:0] cnt_tens;
    logic [DIGIT_W-1:0] cnt_ones;
    logic              cnt_zero;

    logic load_cnt;
    logic dec_cnt;
    logic tick_ok;
    logic sec_tick;
    logic expiry;
    logic adv;

    assign state = cur_state;

    // A tick is accepted in RUN unless a game event wins; pause only outranks it
    // when the tick would not expire the round.
    always_comb begin
        tick_ok  = (cur_state == RUN) && !dot_game_over && !success && tick_1k;
        sec_tick = tick_ok && (ms_cnt == MS_LAST);
        expiry   = sec_tick && (cnt_tens == '0) && (cnt_ones == 4'd1);
        adv      = tick_ok && (!pause || expiry);
        dec_cnt  = adv && sec_tick && !cnt_zero;
        load_cnt = start && ((cur_state == IDLE) || (cur_state == WIN) ||
                             (cur_state == LOSE) || (cur_state == TIMEOVER));
    end

    bcd2_down_counter u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (load_cnt),
        .dec       (dec_cnt),
        .load_tens (START_TENS),
        .load_ones (START_ONES),
        .tens      (cnt_tens),
        .ones      (cnt_ones),
        .zero      (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            ms_cnt    <= '0;
            timeover  <= 1'b0;
            running   <= 1'b0;
        end else begin
            case (cur_state)
                RUN: begin
                    if (dot_game_over) begin
                        cur_state <= LOSE;
                        running   <= 1'b0;
                    end else if (success) begin
                        cur_state <= WIN;
                        running   <= 1'b0;
                    end else if (expiry) begin
                        cur_state <= TIMEOVER;
                        ms_cnt    <= '0;
                        timeover  <= 1'b1;
                        running   <= 1'b0;
                    end else if (pause) begin
                        cur_state <= PAUSE;
                        running   <= 1'b0;
                    end else if (adv) begin
                        ms_cnt <= sec_tick ? '0 : ms_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    if (dot_game_over) begin
                        cur_state <= LOSE;
                    end else if (success) begin
                        cur_state <= WIN;
                    end else if (!pause) begin
                        cur_state <= RUN;
                        running   <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and the terminal states share the (re)start path.
                    if (start) begin
                        ms_cnt    <= '0;
                        timeover  <= ZERO_ROUND;
                        running   <= !ZERO_ROUND;
                        cur_state <= ZERO_ROUND ? TIMEOVER : RUN;
                    end
                end
            endcase
        end
    end

    always_comb begin
        digits = {NUM_DIGITS{DIG_DASH}};
        case (cur_state)
            IDLE, RUN, PAUSE: digits = {{(NUM_DIGITS-2){DIG_BLANK}}, cnt_tens, cnt_ones};
            WIN:              digits = {{(NUM_DIGITS-2){DIG_DASH}}, cnt_tens, cnt_ones};
            default:          digits = {NUM_DIGITS{DIG_DASH}};
        endcase
    end

endmodule
